// File: rtl/lightsout_pkg.sv
// Shared types and constants for the Lights Out input front-end.
package lightsout_pkg;

    localparam int GRID_W_DEFAULT = 5;
    localparam int GRID_H_DEFAULT = 5;

    localparam int IDX_W   = 6;
    localparam int ROW_W   = 3;
    localparam int COL_W   = 3;
    localparam int NUM_BTN = 5;
    localparam int NUM_DIR = 4;

    // Bit positions inside btn_raw: {sel,right,left,down,up}
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } move_state_t;

    // Auto-repeat states, only referenced when auto-repeat is built in
    typedef enum logic [1:0] {
        RPT_REL  = 2'd0,
        RPT_WAIT = 2'd1,
        RPT_RPT  = 2'd2
    } rpt_state_t;

    // Linear cell index row*grid_w+col; 8x8 peaks at 63 so 6 bits never overflow
    function automatic logic [IDX_W-1:0] cell_index(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input logic [IDX_W-1:0] grid_w
    );
        return IDX_W'(row) * grid_w + IDX_W'(col);
    endfunction

endpackage

// File: rtl/lightsout_debounce.sv
// One push-button: 2-FF synchroniser, counter debouncer, registered press pulse.
// The debounced level is exported only when LIGHTSOUT_AUTOREPEAT_EN is defined.
module lightsout_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
`ifdef LIGHTSOUT_AUTOREPEAT_EN
    output logic level_o,
`endif
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive mismatching samples; flip the level on the last one
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, debounce state and rising-edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_raw_i;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

`ifdef LIGHTSOUT_AUTOREPEAT_EN
    assign level_o = level_q;
`endif
    assign press_o = press_q;

endmodule

// File: rtl/lightsout_input_ctrl.sv
// Lights Out input front-end: debounced buttons, wrapping cursor, and a
// single-entry valid/ready move channel toward the game core.
// Optional: LIGHTSOUT_AUTOREPEAT_EN adds held-direction auto-repeat.
module lightsout_input_ctrl
    import lightsout_pkg::*;
#(
    parameter int GRID_W          = GRID_W_DEFAULT,
    parameter int GRID_H          = GRID_H_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 4096,
    parameter int REPEAT_PERIOD   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [ROW_W-1:0]   cur_row,
    output logic [COL_W-1:0]   cur_col,
    output logic               move_valid,
    output logic [IDX_W-1:0]   move_idx,
    input  logic               move_ready,
    output logic               drop_evt
);

    if (GRID_W < 2 || GRID_W > 8 || GRID_H < 2 || GRID_H > 8) begin : g_bad_grid
        $error("lightsout_input_ctrl: GRID_W/GRID_H must be within 2..8");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("lightsout_input_ctrl: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("lightsout_input_ctrl: REPEAT_DELAY/REPEAT_PERIOD must be at least 2");
    end

    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_DIR-1:0] dir_evt;
    logic               sel_evt;

`ifdef LIGHTSOUT_AUTOREPEAT_EN
    logic [NUM_BTN-1:0] btn_level;
`endif

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        lightsout_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .btn_raw_i (btn_raw[gi]),
`ifdef LIGHTSOUT_AUTOREPEAT_EN
            .level_o   (btn_level[gi]),
`endif
            .press_o   (btn_press[gi])
        );
    end

`ifdef LIGHTSOUT_AUTOREPEAT_EN
    localparam int RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_CNT_W = $clog2(RPT_MAX);

    logic [NUM_DIR-1:0] rpt_fire;

    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_rpt
        rpt_state_t           state_q;
        logic [RPT_CNT_W-1:0] cnt_q;

        // Extra event in the cycle the hold timer expires, aligned with press pulses
        assign rpt_fire[gi] = btn_level[gi] &&
            ((state_q == RPT_WAIT && cnt_q == RPT_CNT_W'(REPEAT_DELAY - 1)) ||
             (state_q == RPT_RPT  && cnt_q == RPT_CNT_W'(REPEAT_PERIOD - 1)));

        // Per-direction repeat FSM: press arms the delay, then periodic firing
        always_ff @(posedge clk) begin
            if (rst || !btn_level[gi]) begin
                state_q <= RPT_REL;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    RPT_REL: begin
                        if (btn_press[gi]) begin
                            state_q <= RPT_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    RPT_WAIT, RPT_RPT: begin
                        if (rpt_fire[gi]) begin
                            state_q <= RPT_RPT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + RPT_CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= RPT_REL;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign dir_evt = btn_press[NUM_DIR-1:0] | rpt_fire;
`else
    assign dir_evt = btn_press[NUM_DIR-1:0];
`endif

    assign sel_evt = btn_press[BTN_SEL];

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    // Wrapping cursor step; opposing events on the same axis cancel
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (dir_evt[BTN_UP] && !dir_evt[BTN_DOWN]) begin
            row_d = (row_q == '0) ? ROW_W'(GRID_H - 1) : row_q - ROW_W'(1);
        end else if (dir_evt[BTN_DOWN] && !dir_evt[BTN_UP]) begin
            row_d = (row_q == ROW_W'(GRID_H - 1)) ? '0 : row_q + ROW_W'(1);
        end
        if (dir_evt[BTN_LEFT] && !dir_evt[BTN_RIGHT]) begin
            col_d = (col_q == '0) ? COL_W'(GRID_W - 1) : col_q - COL_W'(1);
        end else if (dir_evt[BTN_RIGHT] && !dir_evt[BTN_LEFT]) begin
            col_d = (col_q == COL_W'(GRID_W - 1)) ? '0 : col_q + COL_W'(1);
        end
    end

    // Cursor registers
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    move_state_t      state_q;
    logic             move_valid_q;
    logic [IDX_W-1:0] move_idx_q;
    logic             drop_q;

    // Move channel: latch pre-move cursor on sel, hold until accepted, drop extras
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            move_valid_q <= 1'b0;
            move_idx_q   <= '0;
            drop_q       <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_evt) begin
                        move_idx_q   <= cell_index(row_q, col_q, IDX_W'(GRID_W));
                        move_valid_q <= 1'b1;
                        state_q      <= PEND;
                    end
                end
                PEND: begin
                    if (move_ready) begin
                        move_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                    if (sel_evt) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    move_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cur_row    = row_q;
    assign cur_col    = col_q;
    assign move_valid = move_valid_q;
    assign move_idx   = move_idx_q;
    assign drop_evt   = drop_q;

endmodule

// File: tb/tb_lightsout_input_ctrl.sv
// Self-checking bench for lightsout_input_ctrl (5x5 grid, DEBOUNCE_CYCLES=4).
module tb_lightsout_input_ctrl;

    localparam int GW = 5;
    localparam int GH = 5;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    localparam logic [4:0] B_UP  = 5'b00001;
    localparam logic [4:0] B_DN  = 5'b00010;
    localparam logic [4:0] B_LT  = 5'b00100;
    localparam logic [4:0] B_RT  = 5'b01000;
    localparam logic [4:0] B_SEL = 5'b10000;

`ifdef LIGHTSOUT_AUTOREPEAT_EN
    localparam int EXP_RPT_CHANGES = 6;
`else
    localparam int EXP_RPT_CHANGES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = 5'b0;
    logic       move_ready = 1'b0;
    logic [2:0] cur_row;
    logic [2:0] cur_col;
    logic       move_valid;
    logic [5:0] move_idx;
    logic       drop_evt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int drop_seen = 0;

    typedef struct {
        logic [4:0] btn;
        int         row;
        int         col;
        int         valid;
        int         idx;
    } vec_t;

    vec_t vecs [14];
    vec_t exp_q [$];

    lightsout_input_ctrl #(
        .GRID_W          (GW),
        .GRID_H          (GH),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .cur_row    (cur_row),
        .cur_col    (cur_col),
        .move_valid (move_valid),
        .move_idx   (move_idx),
        .move_ready (move_ready),
        .drop_evt   (drop_evt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Advance to the next falling edge; inputs change and outputs are sampled here
    task automatic tick();
        @(negedge clk);
        if (drop_evt) drop_seen++;
    endtask

    task automatic press(input logic [4:0] mask);
        btn_raw = mask;
        repeat (8) tick();
        btn_raw = 5'b0;
        repeat (10) tick();
    endtask

    task automatic handshake(input string name);
        move_ready = 1'b1;
        tick();
        check(name, move_valid, 0);
        move_ready = 1'b0;
    endtask

    task automatic apply_vec(input int i);
        vec_t e;
        exp_q.push_back(vecs[i]);
        press(vecs[i].btn);
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL vec%0d_scoreboard: got empty queue, expected one entry", i);
        end else begin
            e = exp_q.pop_front();
            $display("vec%0d btn=%b -> row=%0d col=%0d valid=%0d idx=%0d", i, e.btn,
                     cur_row, cur_col, move_valid, move_idx);
            check($sformatf("vec%0d_row", i), cur_row, e.row);
            check($sformatf("vec%0d_col", i), cur_col, e.col);
            check($sformatf("vec%0d_valid", i), move_valid, e.valid);
            if (e.valid != 0) check($sformatf("vec%0d_idx", i), move_idx, e.idx);
        end
    endtask

    initial begin
        int changes;
        int col_prev;

        vecs[0]  = '{B_DN,        0, 0, 0, 0};
        vecs[1]  = '{B_DN,        1, 0, 0, 0};
        vecs[2]  = '{B_DN,        2, 0, 0, 0};
        vecs[3]  = '{B_RT,        2, 1, 0, 0};
        vecs[4]  = '{B_RT,        2, 2, 0, 0};
        vecs[5]  = '{B_RT,        2, 3, 0, 0};
        vecs[6]  = '{B_SEL,       2, 3, 1, 13};
        vecs[7]  = '{B_UP | B_DN, 0, 0, 0, 0};
        vecs[8]  = '{B_UP | B_LT, 4, 4, 0, 0};
        vecs[9]  = '{B_LT | B_RT, 4, 4, 0, 0};
        vecs[10] = '{B_UP,        3, 4, 0, 0};
        vecs[11] = '{B_RT,        3, 0, 0, 0};
        vecs[12] = '{B_SEL,       3, 0, 1, 15};
        vecs[13] = '{B_DN | B_RT, 4, 1, 1, 15};

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_row", cur_row, 0);
        check("rst_col", cur_col, 0);
        check("rst_valid", move_valid, 0);
        check("rst_idx", move_idx, 0);
        check("rst_drop", drop_evt, 0);

        // Glitch of DEBOUNCE_CYCLES-1 samples is rejected
        btn_raw = B_UP;
        repeat (3) tick();
        btn_raw = 5'b0;
        repeat (10) tick();
        check("glitch_row", cur_row, 0);
        $display("glitch up 3 cycles -> row=%0d", cur_row);

        // Exact latency: update lands on edge N+3+DEBOUNCE_CYCLES, with wrap 0->4
        btn_raw = B_UP;
        repeat (DB + 3) tick();
        check("lat_before_row", cur_row, 0);
        tick();
        check("lat_after_row", cur_row, GH - 1);
        $display("hold up -> row=%0d at N+%0d", cur_row, DB + 3);
        repeat (2) tick();
        btn_raw = 5'b0;
        repeat (10) tick();

        for (int i = 0; i <= 6; i++) apply_vec(i);

        // Pending move holds while game core stalls
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("hold%0d_valid", c), move_valid, 1);
            check($sformatf("hold%0d_idx", c), move_idx, 13);
        end
        $display("stall 20 cycles -> valid=%0d idx=%0d", move_valid, move_idx);

        // Cursor moves while pending; a second sel is dropped
        press(B_LT);
        check("pend_left_col", cur_col, 2);
        drop_seen = 0;
        press(B_SEL);
        check("drop_count", drop_seen, 1);
        check("drop_idx", move_idx, 13);
        check("drop_valid", move_valid, 1);
        $display("sel while pending -> drops=%0d idx=%0d", drop_seen, move_idx);
        handshake("accept_valid");
        $display("move_ready -> valid=%0d", move_valid);

        // Reset while pending with sel held, then fresh acceptance after release
        btn_raw = B_SEL;
        repeat (8) tick();
        check("pre_rst_valid", move_valid, 1);
        check("pre_rst_idx", move_idx, 12);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", move_valid, 0);
        check("mid_rst_row", cur_row, 0);
        check("mid_rst_col", cur_col, 0);
        tick();
        rst = 1'b0;
        repeat (DB + 3) tick();
        check("post_rst_early_valid", move_valid, 0);
        tick();
        check("post_rst_valid", move_valid, 1);
        check("post_rst_idx", move_idx, 0);
        $display("sel held through reset -> valid=%0d idx=%0d", move_valid, move_idx);
        btn_raw = 5'b0;
        repeat (10) tick();
        handshake("post_rst_accept");

        for (int i = 7; i <= 13; i++) apply_vec(i);
        handshake("final_accept");

        // Held direction: single step by default, auto-repeat when built in
        btn_raw = B_RT;
        repeat (DB + 3) tick();
        col_prev = cur_col;
        changes  = 0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (cur_col != col_prev) changes++;
            col_prev = cur_col;
        end
        check("hold_right_changes", changes, EXP_RPT_CHANGES);
        check("hold_right_col", cur_col, (1 + EXP_RPT_CHANGES) % GW);
        check("hold_right_row", cur_row, 4);
        $display("hold right 60 cycles -> changes=%0d col=%0d", changes, cur_col);
        btn_raw = 5'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
